// File: rtl/tlp_frag_sequencer_pkg.sv
// Shared types for the TX data-fragmentation path: arbiter source tags,
// sequencer FSM states and recorder pop-count encodings.
package data_frag_package;

  typedef enum logic [1:0] {
    SRC_POSTED     = 2'd0,
    SRC_NON_POSTED = 2'd1,
    SRC_COMPLETION = 2'd2,
    NO_SOURCE      = 2'd3
  } Tx_Arbiter_Sources_t;

  typedef enum logic [2:0] {IDLE, WAIT, XFER1, XFER2, DONE} Frag_Seq_State_t;

  localparam int         N_SRC  = 3;
  localparam logic [1:0] RD_ONE = 2'b01;
  localparam logic [1:0] RD_TWO = 2'b10;

endpackage

// File: rtl/tlp_frag_sequencer_skid.sv
// Two-entry output FIFO between the source-buffer read path and the DLL;
// each entry carries {data, sop, eop}.
module frag_skid_buffer #(
  parameter int W = 130
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  output logic [1:0]   o_count,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign o_valid = (r_count != 2'd0);
  assign w_pop   = o_valid & i_ready;
  assign o_count = r_count;
  // Storage is not reset, so the data output is forced to 0 while empty.
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (i_wr_en) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)   r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_wr_en} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/tlp_frag_sequencer.sv
// Pops source tags from the sequence recorder and streams each tag's TLP to the DLL.
// Optional perf counters (tlp_cnt, stall_cnt) under `TLP_FRAG_SEQ_PERF_CNT_EN.
module tlp_frag_sequencer
  import data_frag_package::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 257,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst,
  output logic                  rec_rd_en,
  output logic [1:0]            rec_rd_mode,
  input  Tx_Arbiter_Sources_t   rec_rd_data_1,
  input  Tx_Arbiter_Sources_t   rec_rd_data_2,
  input  logic                  rec_empty,
  input  logic [ADDR_WIDTH:0]   rec_available,
  output Tx_Arbiter_Sources_t   src_sel,
  output logic                  src_rd_en,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_last,
  output logic [DATA_WIDTH-1:0] dll_data,
  output logic                  dll_valid,
  output logic                  dll_sop,
  output logic                  dll_eop,
  input  logic                  dll_ready,
  output logic                  start_fragment
`ifdef TLP_FRAG_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]           tlp_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  Frag_Seq_State_t     r_state, w_state_nxt;
  Tx_Arbiter_Sources_t r_tag1, r_tag2;
  logic [1:0]          r_mode;
  logic                r_inflight;
  logic                r_first;

  logic [ADDR_WIDTH:0] w_occ;
  logic [1:0]          w_pop_mode;
  logic [1:0]          w_count;
  logic [2:0]          w_level;
  logic                w_acc, w_space, w_last_ret, w_skid_empty;
  logic [DATA_WIDTH+1:0] w_skid_out;

  assign w_occ      = (ADDR_WIDTH+1)'(FIFO_DEPTH) - rec_available;
  assign w_pop_mode = (w_occ >= (ADDR_WIDTH+1)'(2)) ? RD_TWO : RD_ONE;
  assign w_acc      = dll_valid & dll_ready;
  // Credit includes the beat in flight and the slot freed by this cycle's accept.
  assign w_level    = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_acc};
  assign w_space    = (w_level < 3'd2);
  // Returning last beat: no further read for this tag may be issued.
  assign w_last_ret   = r_inflight & src_last;
  assign w_skid_empty = (w_count == 2'd0) & ~r_inflight;

  always_comb begin
    w_state_nxt = r_state;
    rec_rd_en   = 1'b0;
    rec_rd_mode = 2'b00;
    src_sel     = NO_SOURCE;
    src_rd_en   = 1'b0;
    case (r_state)
      IDLE: if (!rec_empty) begin
        rec_rd_en   = 1'b1;
        rec_rd_mode = w_pop_mode;
        w_state_nxt = WAIT;
      end
      WAIT: w_state_nxt = XFER1;
      XFER1: begin
        src_sel = r_tag1;
        if (r_tag1 == NO_SOURCE) begin
          w_state_nxt = (r_tag2 != NO_SOURCE) ? XFER2 : DONE;
        end else if (!w_last_ret) begin
          src_rd_en = w_space;
        end else begin
          w_state_nxt = (r_tag2 != NO_SOURCE) ? XFER2 : DONE;
          // Start the second TLP while the first one's last beat lands: no bubble.
          if (r_tag2 != NO_SOURCE) begin
            src_sel   = r_tag2;
            src_rd_en = w_space;
          end
        end
      end
      XFER2: begin
        src_sel   = r_tag2;
        src_rd_en = w_space & ~w_last_ret;
        if (w_last_ret) w_state_nxt = DONE;
      end
      DONE: if (w_skid_empty) begin
        w_state_nxt = IDLE;
        if (!rec_empty) begin
          rec_rd_en   = 1'b1;
          rec_rd_mode = w_pop_mode;
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state    <= IDLE;
      r_tag1     <= NO_SOURCE;
      r_tag2     <= NO_SOURCE;
      r_mode     <= RD_ONE;
      r_inflight <= 1'b0;
      r_first    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= src_rd_en;
      if (rec_rd_en) r_mode <= rec_rd_mode;
      if (r_state == WAIT) begin
        r_tag1 <= rec_rd_data_1;
        r_tag2 <= (r_mode == RD_TWO) ? rec_rd_data_2 : NO_SOURCE;
      end
      if (r_inflight) r_first <= src_last;
    end
  end

  frag_skid_buffer #(.W(DATA_WIDTH + 2)) u_skid (
    .clk       (clk),
    .arst      (arst),
    .i_wr_en   (r_inflight),
    .i_wr_data ({src_data, r_first, src_last}),
    .o_count   (w_count),
    .o_valid   (dll_valid),
    .o_data    (w_skid_out),
    .i_ready   (dll_ready)
  );

  assign dll_data       = w_skid_out[DATA_WIDTH+1:2];
  assign dll_sop        = w_skid_out[1];
  assign dll_eop        = w_skid_out[0];
  assign start_fragment = w_acc & dll_eop;

`ifdef TLP_FRAG_SEQ_PERF_CNT_EN
  logic [15:0] r_tlp_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_tlp_cnt   <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (start_fragment && r_tlp_cnt != 16'hFFFF) r_tlp_cnt <= r_tlp_cnt + 16'd1;
      if (dll_valid && !dll_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign tlp_cnt   = r_tlp_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
